// File: rtl/apb_top_module.sv
// apb_top_module
// Self-contained APB subsystem: a user-request-driven APB master FSM
// (IDLE -> SETUP -> ACCESS) talking to an internal APB slave that owns a
// byte-wide register memory of MEM_DEPTH locations.
//
// Ports:
//   pclk             system clock, all state changes on the rising edge
//   presetn          asynchronous reset, ACTIVE-HIGH despite the legacy name
//   read_write       1 = write request, 0 = read request
//   transfer         request valid, level-sensitive (hold high for back-to-back)
//   apb_write_paddr  target address used for write requests
//   apb_read_paddr   target address used for read requests
//   apb_write_data   write data
//   pready           transfer-complete strobe, high in the completing ACCESS cycle
//   pslaverr         error flag, only ever high together with pready
//   prdata           registered data of the last read completion
//
// Optional feature (macro APB_WAIT_STATE_EN):
//   When defined, the slave inserts exactly one wait state per transfer, so
//   each transfer takes SETUP + two ACCESS cycles. When undefined, the slave
//   is zero-wait-state and each transfer takes SETUP + one ACCESS cycle.

module apb_top_module #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  read_write,
    input  logic                  transfer,
    input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
    input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
    input  logic [DATA_WIDTH-1:0] apb_write_data,
    output logic                  pready,
    output logic                  pslaverr,
    output logic [DATA_WIDTH-1:0] prdata
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // One extra bit so MEM_DEPTH itself is representable even when it equals
    // 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = MEM_DEPTH[ADDR_WIDTH:0];

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state, next_state;

    logic                  psel;
    logic                  penable;
    logic                  capture;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  addr_err;
    logic                  complete;
    logic [MEM_AW-1:0]     mem_idx;

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    // State register.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the master's APB control strobes. A new request is
    // captured whenever we enter SETUP, either from IDLE or straight out of a
    // completing ACCESS cycle, which gives back-to-back transfers without an
    // IDLE gap.
    always_comb begin
        next_state = state;
        psel       = 1'b0;
        penable    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    next_state = SETUP;
                    capture    = 1'b1;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    if (transfer) begin
                        next_state = SETUP;
                        capture    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture. The address mux picks the write or read address based
    // on the request direction; nothing changes again until the next capture,
    // so the user side may move its inputs freely while a transfer is in flight.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (capture) begin
            pwrite <= read_write;
            paddr  <= read_write ? apb_write_paddr : apb_read_paddr;
            pwdata <= apb_write_data;
        end
    end

`ifdef APB_WAIT_STATE_EN
    logic wait_done;

    // Set during the first ACCESS cycle so the second one completes; cleared
    // again as soon as that completing cycle has passed.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            wait_done <= 1'b0;
        end else begin
            wait_done <= (state == ACCESS) && !wait_done;
        end
    end

    assign pready = (state == ACCESS) && wait_done;
`else
    assign pready = (state == ACCESS);
`endif

    assign addr_err = ({1'b0, paddr} >= DEPTH_LIMIT);
    assign pslaverr = pready & addr_err;
    assign complete = psel & penable & pready;

    // Only used when addr_err is low, so the dropped upper bits are zero.
    assign mem_idx  = paddr[MEM_AW-1:0];

    // Slave memory and read-data register. Out-of-range writes are dropped and
    // out-of-range reads return zero; prdata only moves on read completions.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
            prdata <= '0;
        end else if (complete) begin
            if (pwrite) begin
                if (!addr_err) begin
                    mem[mem_idx] <= pwdata;
                end
            end else begin
                prdata <= addr_err ? '0 : mem[mem_idx];
            end
        end
    end

endmodule

// File: tb/tb_apb_top_module.sv
// tb_apb_top_module
// Directed testbench for apb_top_module in its default (zero-wait-state)
// build. Inputs are driven and outputs are sampled on the falling edge of
// pclk, half a cycle away from the active edge.

module tb_apb_top_module;

    logic       pclk;
    logic       presetn;
    logic       read_write;
    logic       transfer;
    logic [7:0] apb_write_paddr;
    logic [7:0] apb_read_paddr;
    logic [7:0] apb_write_data;
    logic       pready;
    logic       pslaverr;
    logic [7:0] prdata;

    int tests;
    int failures;

    apb_top_module #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .MEM_DEPTH (64)
    ) dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .read_write     (read_write),
        .transfer       (transfer),
        .apb_write_paddr(apb_write_paddr),
        .apb_read_paddr (apb_read_paddr),
        .apb_write_data (apb_write_data),
        .pready         (pready),
        .pslaverr       (pslaverr),
        .prdata         (prdata)
    );

    // 10 ns clock.
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Safety net so the run always ends even if the sequence gets stuck.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on a miss counts the failure and reports.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    // Single isolated transfer: request is presented at a falling edge and
    // dropped during SETUP. Checks the SETUP, ACCESS and following IDLE cycles.
    // The unused address input is loaded with a decoy to expose a wrong mux.
    task automatic applyStimulus(input logic rw, input logic [7:0] addr,
                                 input logic [7:0] data, input logic exp_err,
                                 input logic [7:0] exp_rd, input string tag);
        read_write     = rw;
        transfer       = 1'b1;
        apb_write_data = data;
        if (rw) begin
            apb_write_paddr = addr;
            apb_read_paddr  = ~addr;
        end else begin
            apb_read_paddr  = addr;
            apb_write_paddr = ~addr;
        end
        @(negedge pclk);
        transfer = 1'b0;
        checkOutput({tag, " setup pready"}, {7'b0, pready}, 8'h00);
        @(negedge pclk);
        checkOutput({tag, " access pready"}, {7'b0, pready}, 8'h01);
        checkOutput({tag, " access pslaverr"}, {7'b0, pslaverr}, {7'b0, exp_err});
        @(negedge pclk);
        checkOutput({tag, " idle pready"}, {7'b0, pready}, 8'h00);
        if (!rw) begin
            checkOutput({tag, " prdata"}, prdata, exp_rd);
        end
    endtask

    initial begin
        tests           = 0;
        failures        = 0;
        presetn         = 1'b1;
        read_write      = 1'b0;
        transfer        = 1'b0;
        apb_write_paddr = 8'h00;
        apb_read_paddr  = 8'h00;
        apb_write_data  = 8'h00;

        // Reset for two cycles, then release.
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b0;
        @(negedge pclk);
        checkOutput("reset pready", {7'b0, pready}, 8'h00);
        checkOutput("reset pslaverr", {7'b0, pslaverr}, 8'h00);
        checkOutput("reset prdata", prdata, 8'h00);

        // Single write then read.
        applyStimulus(1'b1, 8'h15, 8'hA5, 1'b0, 8'h00, "wr 15");
        applyStimulus(1'b0, 8'h15, 8'h00, 1'b0, 8'hA5, "rd 15");

        // Back-to-back with transfer held high. Inputs for the next request
        // are changed during SETUP, which must not disturb the transfer in
        // flight.
        read_write      = 1'b1;
        transfer        = 1'b1;
        apb_write_paddr = 8'h20;
        apb_read_paddr  = 8'h11;
        apb_write_data  = 8'hB5;
        @(negedge pclk);
        checkOutput("b2b wr20 setup pready", {7'b0, pready}, 8'h00);
        read_write     = 1'b0;
        apb_read_paddr = 8'h20;
        apb_write_data = 8'hEE;
        @(negedge pclk);
        checkOutput("b2b wr20 access pready", {7'b0, pready}, 8'h01);
        @(negedge pclk);
        checkOutput("b2b rd20 setup pready", {7'b0, pready}, 8'h00);
        read_write      = 1'b1;
        apb_write_paddr = 8'h30;
        apb_write_data  = 8'h65;
        @(negedge pclk);
        checkOutput("b2b rd20 access pready", {7'b0, pready}, 8'h01);
        @(negedge pclk);
        checkOutput("b2b wr30 setup pready", {7'b0, pready}, 8'h00);
        checkOutput("b2b prdata after rd20", prdata, 8'hB5);
        read_write     = 1'b0;
        apb_read_paddr = 8'h30;
        @(negedge pclk);
        checkOutput("b2b wr30 access pready", {7'b0, pready}, 8'h01);
        checkOutput("b2b prdata held on write", prdata, 8'hB5);
        @(negedge pclk);
        checkOutput("b2b rd30 setup pready", {7'b0, pready}, 8'h00);
        transfer = 1'b0;
        @(negedge pclk);
        checkOutput("b2b rd30 access pready", {7'b0, pready}, 8'h01);
        @(negedge pclk);
        checkOutput("b2b prdata after rd30", prdata, 8'h65);
        checkOutput("b2b idle pready", {7'b0, pready}, 8'h00);

        // Out-of-range write and read; 0x50 aliases 0x10 in the low bits, so
        // 0x10 must still read back zero. 0x40 is the first invalid address.
        applyStimulus(1'b1, 8'h50, 8'h77, 1'b1, 8'h00, "err wr 50");
        applyStimulus(1'b0, 8'h50, 8'h00, 1'b1, 8'h00, "err rd 50");
        applyStimulus(1'b0, 8'h10, 8'h00, 1'b0, 8'h00, "rd 10 untouched");
        applyStimulus(1'b0, 8'h20, 8'h00, 1'b0, 8'hB5, "rd 20 again");
        applyStimulus(1'b0, 8'h40, 8'h00, 1'b1, 8'h00, "err rd 40");

        // Transfer dropped during SETUP of a write to the top valid address.
        applyStimulus(1'b1, 8'h3F, 8'h12, 1'b0, 8'h00, "drop wr 3F");
        @(negedge pclk);
        checkOutput("drop stays idle", {7'b0, pready}, 8'h00);
        applyStimulus(1'b0, 8'h3F, 8'h00, 1'b0, 8'h12, "rd 3F");

        // Reset asserted in the ACCESS cycle of a write.
        read_write      = 1'b1;
        transfer        = 1'b1;
        apb_write_paddr = 8'h10;
        apb_write_data  = 8'hCC;
        @(negedge pclk);
        transfer = 1'b0;
        @(negedge pclk);
        checkOutput("midrst access pready", {7'b0, pready}, 8'h01);
        presetn = 1'b1;
        #1;
        checkOutput("midrst pready", {7'b0, pready}, 8'h00);
        checkOutput("midrst pslaverr", {7'b0, pslaverr}, 8'h00);
        checkOutput("midrst prdata", prdata, 8'h00);
        @(negedge pclk);
        presetn = 1'b0;
        @(negedge pclk);
        applyStimulus(1'b0, 8'h10, 8'h00, 1'b0, 8'h00, "rd 10 after rst");
        applyStimulus(1'b0, 8'h15, 8'h00, 1'b0, 8'h00, "rd 15 after rst");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
